debounce_multi: RTL and testbench
=================================

# debounce_multi

Multi-channel, parametrised successor to the single-input debounce block. Each of `CH` independent mechanical-switch inputs is optionally synchronised, then filtered so its output changes only after the input holds a new level for `STABLE` consecutive clocks. Per-channel rise/fall pulses and sticky, software-clearable event flags are generated. It sits between raw board-level switch/button pins and the control logic or register file that consumes clean levels and edge events.

## Interface
- `CH`, default 4: number of independent channels; at least 1.
- `CNT_W`, default 7: stability counter width per channel.
- `STABLE`, default 10: consecutive mismatching samples required to accept a new level; 1 ≤ `STABLE` ≤ 2^`CNT_W`−1, checked at elaboration.
- `clk` in, 1 bit: single clock; all state updates on the rising edge.
- `rstn` in, 1 bit: asynchronous, active-low reset.
- `in` in, `CH` bits: raw switch inputs, asynchronous to `clk`.
- `out` out, `CH` bits: debounced levels.
- `rise` out, `CH` bits: one-cycle pulse on the edge where `out[i]` goes 0→1.
- `fall` out, `CH` bits: one-cycle pulse on the edge where `out[i]` goes 1→0.
- `evt` out, `CH` bits: sticky flag, set by any transition of `out[i]`.
- `evt_clr` in, `CH` bits: per-channel synchronous clear of `evt[i]`.

## Operation
- Channels are fully independent. There is no cross-channel interaction.
- Sampled level `s[i]`: output of the synchroniser, or `in[i]` directly (see Configuration).
- Per-channel counter `cnt[i]` is `CNT_W` bits.
- If `s[i] == out[i]`: `cnt[i]` ← 0. A single matching sample aborts any pending change (glitch rejection).
- If `s[i] != out[i]` and `cnt[i] < STABLE−1`: `cnt[i]` ← `cnt[i]`+1.
- If `s[i] != out[i]` and `cnt[i] == STABLE−1`:
  - `out[i]` ← `s[i]` and `cnt[i]` ← 0.
  - `rise[i]` or `fall[i]` is asserted for exactly that one cycle, registered with `out[i]`.
- The counter never exceeds `STABLE−1`, so no wrap-around is possible.
- `evt[i]` behaviour:
  - Set in the same cycle `rise[i]` or `fall[i]` is asserted.
  - Cleared on an edge where `evt_clr[i]` is 1.
  - If set and clear coincide, set wins and `evt[i]` stays 1.
  - `evt_clr[i]` with no event pending has no effect.
- States per channel:
  - STABLE_IDLE: `cnt` = 0.
  - PENDING: `cnt` > 0.
  - PENDING → STABLE_IDLE on a match, or on acceptance of the new level, which also flips `out`.
- `STABLE` = 1: `out[i]` follows `s[i]` with one clock of delay, and pulses fire on every `s` change.

## Timing
- Reset values: `out` = 0, `rise` = 0, `fall` = 0, `evt` = 0, all `cnt` = 0, synchroniser flops = 0.
- Asserting `rstn` mid-count discards pending changes immediately. After release, a channel whose `in` is held high needs a full qualification before `out` rises.
- Latency, counted in rising edges from the first edge that samples the new `in` level until `out` updates:
  - `STABLE`+2 with the synchroniser compiled in.
  - `STABLE` without it.
- `rise`/`fall` assert on the same edge as the `out` change and deassert on the next edge.
- `evt` updates on that same edge.
- `evt_clr` takes effect on the edge where it is sampled; `evt` reads 0 the following cycle.
- Outputs are all registered, with no combinational path from inputs to outputs.

## Configuration
- `DEBOUNCE_SYNC_EN` defined: a two-flop synchroniser per channel (reset to 0) precedes the filter.
- Not defined: `s[i]` = `in[i]`, for inputs already synchronous to `clk`. Latency drops by 2 edges; all other behaviour is identical.

## Structure
- Shared package `debounce_pkg`:
  - Default parameter constants `DEB_CH_DEF`, `DEB_CNT_W_DEF`, `DEB_STABLE_DEF`.
  - Per-channel state enum {`DEB_IDLE`, `DEB_PENDING`} used for debug visibility.
- Sub-module `debounce_chan`: one channel (optional synchroniser, counter, `out`, `rise`, `fall`, `evt`), instantiated `CH` times by a generate loop in `debounce_multi`.

## Test plan
- Reset check (`CH`=4, `CNT_W`=7, `STABLE`=10, sync on): hold `rstn`=0 with `in`=4'hF → all outputs 0. Release `rstn` → `out`=4'hF exactly 12 edges later; `rise`=4'hF for one cycle; `evt`=4'hF.
- Bounce rejection: toggle `in[0]` every 4 clocks for 20 toggles, then hold 1 → `out[0]` stays 0 throughout the bounce. It rises 12 edges after the final toggle, with exactly one `rise[0]` pulse.
- Boundary: hold mismatch on `in[1]` for 9 samples, then one matching sample, then mismatch again → no change until 10 further consecutive samples; verify `cnt` never exceeds 9.
- Independence: switch `in[2]` on while `in[3]` bounces → `out[2]` rises at +12 edges, `out[3]` remains 0, and `evt` = 4'b0100.
- Event clear race: assert `evt_clr[0]` on the same edge as `fall[0]` → `evt[0]` stays 1. A later `evt_clr[0]` → `evt[0]` = 0 the next cycle.
- Reset mid-operation plus macro-off build: pulse `rstn` low during PENDING → `cnt` = 0 and `out` = 0. Rebuild without `DEBOUNCE_SYNC_EN` → latency is exactly 10 edges.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel switch debouncer: default
// parameter values and the per-channel filter state used for debug visibility.
package debounce_pkg;

  localparam int DEB_CH_DEF     = 4;
  localparam int DEB_CNT_W_DEF  = 7;
  localparam int DEB_STABLE_DEF = 10;

  typedef enum logic {
    DEB_IDLE    = 1'b0,
    DEB_PENDING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: optional two-flop synchroniser, stability counter,
// registered level, edge pulses and sticky event flag (DEBOUNCE_SYNC_EN).
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W  = DEB_CNT_W_DEF,
  parameter int STABLE = DEB_STABLE_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_in,
  input  logic i_evt_clr,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_evt
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE - 1);

  logic             w_s;
  logic             w_mismatch;
  logic             w_accept;
  deb_state_e       w_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_rise;
  logic             r_fall;
  logic             r_evt;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_in};
    end
  end

  assign w_s = r_sync[1];
`else
  assign w_s = i_in;
`endif

  // A new level is accepted on the STABLE-th consecutive mismatching sample.
  assign w_mismatch = (w_s != r_out);
  assign w_accept   = w_mismatch && (r_cnt == LP_LAST);
  assign w_state    = (r_cnt == '0) ? DEB_IDLE : DEB_PENDING;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else begin
      unique case (w_state)
        DEB_IDLE: begin
          if (w_mismatch && !w_accept) begin
            r_cnt <= CNT_W'(1);
          end
        end
        DEB_PENDING: begin
          if (w_mismatch && !w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept && w_s;
      r_fall <= w_accept && !w_s;
      if (w_accept) begin
        r_out <= w_s;
      end
    end
  end

  // A coinciding clear loses against a new event so no transition is missed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_evt <= 1'b0;
    end else begin
      r_evt <= w_accept | (r_evt & ~i_evt_clr);
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_evt  = r_evt;

endmodule

// File: rtl/debounce_multi.sv
// CH independent switch debouncers with rise/fall pulses and clearable event
// flags; DEBOUNCE_SYNC_EN adds a two-flop input synchroniser per channel.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CH     = DEB_CH_DEF,
  parameter int CNT_W  = DEB_CNT_W_DEF,
  parameter int STABLE = DEB_STABLE_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] evt,
  input  logic [CH-1:0] evt_clr
);

  if (CH < 1) begin : g_bad_ch
    $error("debounce_multi: CH must be at least 1");
  end

  if ((STABLE < 1) || (STABLE > (2 ** CNT_W) - 1)) begin : g_bad_stable
    $error("debounce_multi: STABLE must lie in 1 .. 2**CNT_W-1");
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    debounce_chan #(
      .CNT_W  (CNT_W),
      .STABLE (STABLE)
    ) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .i_in      (in[gi]),
      .i_evt_clr (evt_clr[gi]),
      .o_out     (out[gi]),
      .o_rise    (rise[gi]),
      .o_fall    (fall[gi]),
      .o_evt     (evt[gi])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random
// switching, compared every cycle against a sample-history reference model.
module tb_debounce_multi;

  localparam int CH     = 4;
  localparam int CNT_W  = 7;
  localparam int STABLE = 10;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif
  localparam int LAT = STABLE + SYNC_D;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [CH-1:0] tbIn = '0;
  logic [CH-1:0] tbClr = '0;
  logic [CH-1:0] out, rise, fall, evt;

  int nAssert = 0;
  int nFail   = 0;
  int rise0Count = 0;

  logic [CH-1:0] inHist[$];
  logic [CH-1:0] sHist[$];
  logic [CH-1:0] mOut, mRise, mFall, mEvt;

  always #5 clk = ~clk;

  debounce_multi #(.CH(CH), .CNT_W(CNT_W), .STABLE(STABLE)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .in      (tbIn),
    .out     (out),
    .rise    (rise),
    .fall    (fall),
    .evt     (evt),
    .evt_clr (tbClr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelClear();
    inHist.delete();
    sHist.delete();
    mOut = '0; mRise = '0; mFall = '0; mEvt = '0;
  endtask

  // Level flips when the last STABLE post-reset samples all differ from it.
  task automatic modelEdge();
    logic [CH-1:0] s;
    bit allDiff;
    inHist.push_back(tbIn);
    if (inHist.size() > SYNC_D) s = inHist[inHist.size() - 1 - SYNC_D];
    else s = '0;
    sHist.push_back(s);
    mRise = '0;
    mFall = '0;
    for (int c = 0; c < CH; c++) begin
      if (sHist.size() >= STABLE) begin
        allDiff = 1'b1;
        for (int k = 0; k < STABLE; k++)
          if (sHist[sHist.size() - 1 - k][c] == mOut[c]) allDiff = 1'b0;
        if (allDiff) begin
          if (mOut[c]) mFall[c] = 1'b1;
          else mRise[c] = 1'b1;
          mOut[c] = ~mOut[c];
        end
      end
    end
    mEvt = (mEvt & ~tbClr) | mRise | mFall;
  endtask

  task automatic applyStimulus(input logic [CH-1:0] inVal, input logic [CH-1:0] clrVal);
    tbIn  = inVal;
    tbClr = clrVal;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge();
      #1;
      if (rise[0]) rise0Count++;
      checkOutput("out", 32'(out), 32'(mOut));
      checkOutput("rise", 32'(rise), 32'(mRise));
      checkOutput("fall", 32'(fall), 32'(mFall));
      checkOutput("evt", 32'(evt), 32'(mEvt));
    end
  endtask

  task automatic applyReset(input logic [CH-1:0] inVal);
    rstn = 1'b0;
    tbIn = inVal;
    tbClr = '0;
    modelClear();
    #1;
    checkOutput("rst_out", 32'(out), 32'h0);
    checkOutput("rst_evt", 32'(evt), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_hold_out", 32'(out), 32'h0);
    checkOutput("rst_hold_rise", 32'(rise), 32'h0);
    checkOutput("rst_hold_fall", 32'(fall), 32'h0);
    checkOutput("rst_hold_evt", 32'(evt), 32'h0);
    rstn = 1'b1;
  endtask

  initial begin
    logic [CH-1:0] v;
    logic [CH-1:0] c;
    modelClear();
    @(posedge clk);
    #1;

    // Reset with all inputs high, then full qualification.
    applyReset(4'hF);
    runCycles(LAT - 1);
    checkOutput("rel_out_early", 32'(out), 32'h0);
    runCycles(1);
    checkOutput("rel_out", 32'(out), 32'hF);
    checkOutput("rel_rise", 32'(rise), 32'hF);
    checkOutput("rel_evt", 32'(evt), 32'hF);
    runCycles(1);
    checkOutput("rel_rise_clr", 32'(rise), 32'h0);

    // Bounce on channel 0 must never pass.
    applyReset(4'h0);
    runCycles(2);
    rise0Count = 0;
    v = 4'h0;
    for (int t = 0; t < 20; t++) begin
      v[0] = ~v[0];
      applyStimulus(v, '0);
      runCycles(4);
    end
    checkOutput("bounce_out0", 32'(out[0]), 32'h0);
    v[0] = 1'b1;
    applyStimulus(v, '0);
    runCycles(LAT - 1);
    checkOutput("bounce_early", 32'(out[0]), 32'h0);
    runCycles(1);
    checkOutput("bounce_out1", 32'(out[0]), 32'h1);
    checkOutput("bounce_rise", 32'(rise[0]), 32'h1);
    runCycles(3);
    checkOutput("bounce_rise_n", 32'(rise0Count), 32'd1);

    // Nine mismatches, one match, then a fresh full qualification.
    v[1] = 1'b1;
    applyStimulus(v, '0);
    runCycles(STABLE - 1);
    v[1] = 1'b0;
    applyStimulus(v, '0);
    runCycles(1);
    v[1] = 1'b1;
    applyStimulus(v, '0);
    runCycles(LAT - 1);
    checkOutput("bnd_early", 32'(out[1]), 32'h0);
    runCycles(1);
    checkOutput("bnd_out", 32'(out[1]), 32'h1);

    // Channel 2 switches while channel 3 bounces.
    applyStimulus(v, 4'hF);
    runCycles(1);
    v[2] = 1'b1;
    for (int t = 0; t < LAT; t++) begin
      if (t % 3 == 0) v[3] = ~v[3];
      applyStimulus(v, '0);
      runCycles(1);
    end
    checkOutput("ind_out2", 32'(out[2]), 32'h1);
    checkOutput("ind_out3", 32'(out[3]), 32'h0);
    checkOutput("ind_evt", 32'(evt), 32'h4);
    v[3] = 1'b0;
    applyStimulus(v, '0);
    runCycles(LAT + 2);

    // Clear coinciding with a fall keeps the flag set.
    applyStimulus(v, 4'hF);
    runCycles(1);
    v[0] = 1'b0;
    applyStimulus(v, '0);
    runCycles(LAT - 1);
    applyStimulus(v, 4'h1);
    runCycles(1);
    checkOutput("race_fall", 32'(fall[0]), 32'h1);
    checkOutput("race_evt", 32'(evt[0]), 32'h1);
    applyStimulus(v, '0);
    runCycles(2);
    checkOutput("race_evt_hold", 32'(evt[0]), 32'h1);
    applyStimulus(v, 4'h1);
    runCycles(1);
    applyStimulus(v, '0);
    checkOutput("clr_evt", 32'(evt[0]), 32'h0);

    // Reset in the middle of pending changes.
    applyStimulus(~v, '0);
    runCycles(5);
    applyReset(4'hF);
    runCycles(LAT - 1);
    checkOutput("mid_rst_early", 32'(out), 32'h0);
    runCycles(1);
    checkOutput("mid_rst_out", 32'(out), 32'hF);

    // Random switching with occasional clears.
    v = tbIn;
    for (int t = 0; t < 3000; t++) begin
      c = '0;
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(7) == 0) v[ch] = ~v[ch];
        if ($urandom_range(15) == 0) c[ch] = 1'b1;
      end
      applyStimulus(v, c);
      runCycles(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
